// File: rtl/al4s3b_fpga_ram_arbiter.sv
// Purpose : two-port arbiter (Wishbone slave + fabric requester) sharing one synchronous single-port RAM.
// Latency : request seen in IDLE at cycle N -> RAM strobe N+1 -> read data captured end of N+2 -> ACK/VLD pulse N+3.
// Backpressure: requests are held by the sources until served; alternating priority under contention, no aborts.
//
// Ports:
//   WBs_*   Wishbone slave side (CYC/STB/WE/ADR/BYTE_STB/DAT_i in, DAT_o/ACK_o out)
//   FAB_*   fabric requester (REQ/WE/ADR/BE/DAT_i in, GNT/VLD/DAT_o out)
//   RAM_*   RAM port (ADR/WEN/REN/WR_DAT out, RD_DAT in, read data valid one cycle after REN)
module al4s3b_fpga_ram_arbiter #(
    parameter int ADDRWIDTH = 11,
    parameter int DATAWIDTH = 32
) (
    input  logic                   WBs_CLK_i,
    input  logic                   WBs_RST_i,
    input  logic [ADDRWIDTH-1:0]   WBs_ADR_i,
    input  logic                   WBs_CYC_i,
    input  logic                   WBs_STB_i,
    input  logic                   WBs_WE_i,
    input  logic [DATAWIDTH/8-1:0] WBs_BYTE_STB_i,
    input  logic [DATAWIDTH-1:0]   WBs_DAT_i,
    output logic [DATAWIDTH-1:0]   WBs_DAT_o,
    output logic                   WBs_ACK_o,
    input  logic                   FAB_REQ_i,
    input  logic                   FAB_WE_i,
    input  logic [ADDRWIDTH-1:0]   FAB_ADR_i,
    input  logic [DATAWIDTH/8-1:0] FAB_BE_i,
    input  logic [DATAWIDTH-1:0]   FAB_DAT_i,
    output logic                   FAB_GNT_o,
    output logic                   FAB_VLD_o,
    output logic [DATAWIDTH-1:0]   FAB_DAT_o,
    output logic [ADDRWIDTH-1:0]   RAM_ADR_o,
    output logic [DATAWIDTH/8-1:0] RAM_WEN_o,
    output logic                   RAM_REN_o,
    output logic [DATAWIDTH-1:0]   RAM_WR_DAT_o,
    input  logic [DATAWIDTH-1:0]   RAM_RD_DAT_i
);

    localparam int BEW = DATAWIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t               state;
    logic                 last_gnt_fab;   // 1 = fabric won the most recent grant
    logic                 skip_wb;        // high for the one IDLE cycle after a Wishbone RESP
    logic                 cap_fab;        // source of the transfer in flight
    logic                 cap_we;
    logic [ADDRWIDTH-1:0] cap_adr;
    logic [BEW-1:0]       cap_be;
    logic [DATAWIDTH-1:0] cap_dat;

    logic                 wb_vld;
    logic                 fab_vld;
    logic                 win_fab;
    logic                 sel_we;
    logic [ADDRWIDTH-1:0] sel_adr;
    logic [BEW-1:0]       sel_be;
    logic [DATAWIDTH-1:0] sel_dat;

    // The Wishbone master still has CYC/STB high in the cycle right after its
    // ACK; ignoring that cycle prevents a phantom second access.
    assign wb_vld  = WBs_CYC_i & WBs_STB_i & ~skip_wb;
    assign fab_vld = FAB_REQ_i;

    // Under contention the source that did not win last time goes first.
    assign win_fab = fab_vld & (~wb_vld | ~last_gnt_fab);

    always_comb begin
        sel_we  = WBs_WE_i;
        sel_adr = WBs_ADR_i;
        sel_be  = WBs_BYTE_STB_i;
        sel_dat = WBs_DAT_i;
        if (win_fab) begin
            sel_we  = FAB_WE_i;
            sel_adr = FAB_ADR_i;
            sel_be  = FAB_BE_i;
            sel_dat = FAB_DAT_i;
        end
    end

    // Address and write data only matter while a strobe is up (XFER).
    assign RAM_ADR_o    = cap_adr;
    assign RAM_WR_DAT_o = cap_dat;

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state        <= IDLE;
            last_gnt_fab <= 1'b1;
            skip_wb      <= 1'b0;
            cap_fab      <= 1'b0;
            cap_we       <= 1'b0;
            cap_adr      <= '0;
            cap_be       <= '0;
            cap_dat      <= '0;
            RAM_WEN_o    <= '0;
            RAM_REN_o    <= 1'b0;
            FAB_GNT_o    <= 1'b0;
            FAB_VLD_o    <= 1'b0;
            FAB_DAT_o    <= '0;
            WBs_ACK_o    <= 1'b0;
            WBs_DAT_o    <= '0;
        end else begin
            // Strobes and pulses are single-cycle; re-asserted only below.
            RAM_WEN_o <= '0;
            RAM_REN_o <= 1'b0;
            FAB_GNT_o <= 1'b0;
            FAB_VLD_o <= 1'b0;
            WBs_ACK_o <= 1'b0;
            skip_wb   <= 1'b0;

            case (state)
                IDLE: begin
                    if (wb_vld | fab_vld) begin
                        state        <= XFER;
                        last_gnt_fab <= win_fab;
                        cap_fab      <= win_fab;
                        cap_we       <= sel_we;
                        cap_adr      <= sel_adr;
                        cap_be       <= sel_be;
                        cap_dat      <= sel_dat;
                        RAM_WEN_o    <= sel_we ? sel_be : '0;
                        RAM_REN_o    <= ~sel_we;
                        FAB_GNT_o    <= win_fab;
                    end
                end
                XFER: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // RAM read data is valid now, one cycle after REN.
                    state <= RESP;
                    if (!cap_we) begin
                        if (cap_fab) FAB_DAT_o <= RAM_RD_DAT_i;
                        else         WBs_DAT_o <= RAM_RD_DAT_i;
                    end
                    WBs_ACK_o <= ~cap_fab;
                    FAB_VLD_o <= cap_fab;
                end
                RESP: begin
                    state   <= IDLE;
                    skip_wb <= ~cap_fab;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_al4s3b_fpga_ram_arbiter.sv
// Directed bench for al4s3b_fpga_ram_arbiter with a byte-writable synchronous RAM model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected values are hand-computed constants.
module tb_al4s3b_fpga_ram_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wb_adr;
    logic          wb_cyc, wb_stb, wb_we;
    logic [3:0]    wb_be;
    logic [DW-1:0] wb_dat_w;
    logic [DW-1:0] wb_dat_r;
    logic          wb_ack;
    logic          fab_req, fab_we;
    logic [AW-1:0] fab_adr;
    logic [3:0]    fab_be;
    logic [DW-1:0] fab_dat_w;
    logic          fab_gnt, fab_vld;
    logic [DW-1:0] fab_dat_r;
    logic [AW-1:0] ram_adr;
    logic [3:0]    ram_wen;
    logic          ram_ren;
    logic [DW-1:0] ram_wr_dat;
    logic [DW-1:0] ram_rd_dat;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    al4s3b_fpga_ram_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
        .WBs_CLK_i      (clk),
        .WBs_RST_i      (rst),
        .WBs_ADR_i      (wb_adr),
        .WBs_CYC_i      (wb_cyc),
        .WBs_STB_i      (wb_stb),
        .WBs_WE_i       (wb_we),
        .WBs_BYTE_STB_i (wb_be),
        .WBs_DAT_i      (wb_dat_w),
        .WBs_DAT_o      (wb_dat_r),
        .WBs_ACK_o      (wb_ack),
        .FAB_REQ_i      (fab_req),
        .FAB_WE_i       (fab_we),
        .FAB_ADR_i      (fab_adr),
        .FAB_BE_i       (fab_be),
        .FAB_DAT_i      (fab_dat_w),
        .FAB_GNT_o      (fab_gnt),
        .FAB_VLD_o      (fab_vld),
        .FAB_DAT_o      (fab_dat_r),
        .RAM_ADR_o      (ram_adr),
        .RAM_WEN_o      (ram_wen),
        .RAM_REN_o      (ram_ren),
        .RAM_WR_DAT_o   (ram_wr_dat),
        .RAM_RD_DAT_i   (ram_rd_dat)
    );

    // Synchronous RAM: byte writes, read data one cycle after REN.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_wen[b]) mem[ram_adr][8*b +: 8] <= ram_wr_dat[8*b +: 8];
        if (ram_ren) ram_rd_dat <= mem[ram_adr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Wishbone transfer starting in the current (clean IDLE) cycle N.
    // CYC/STB stay high through ACK and the following IDLE cycle, which must be ignored.
    task automatic do_wb(input string tag, input logic we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [3:0] be, input logic [DW-1:0] exp_rd);
        wb_adr = adr; wb_we = we; wb_dat_w = dat; wb_be = be;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        tick();                                  // N+1: XFER
        check({tag, " wen@N+1"}, ram_wen, we ? be : 4'h0);
        check({tag, " ren@N+1"}, ram_ren, !we);
        check({tag, " adr@N+1"}, ram_adr, adr);
        if (we) check({tag, " wdat@N+1"}, ram_wr_dat, dat);
        tick();                                  // N+2: WAIT
        check({tag, " ack@N+2"}, wb_ack, 1'b0);
        check({tag, " wen@N+2"}, ram_wen, 4'h0);
        tick();                                  // N+3: RESP
        check({tag, " ack@N+3"}, wb_ack, 1'b1);
        if (!we) check({tag, " rdat@N+3"}, wb_dat_r, exp_rd);
        tick();                                  // IDLE, request still held
        check({tag, " ack one-shot"}, wb_ack, 1'b0);
        tick();                                  // held request in that IDLE cycle is ignored
        check({tag, " no repeat strobe"}, {ram_wen, ram_ren}, 5'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    // Fabric transfer starting in the current (clean IDLE) cycle N; request dropped on grant.
    task automatic do_fab(input string tag, input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat, input logic [3:0] be);
        fab_adr = adr; fab_we = we; fab_dat_w = dat; fab_be = be;
        fab_req = 1'b1;
        tick();                                  // N+1
        check({tag, " gnt@N+1"}, fab_gnt, 1'b1);
        check({tag, " wen@N+1"}, ram_wen, we ? be : 4'h0);
        check({tag, " ren@N+1"}, ram_ren, !we);
        check({tag, " adr@N+1"}, ram_adr, adr);
        fab_req = 1'b0;
        tick();                                  // N+2
        check({tag, " gnt one-shot"}, fab_gnt, 1'b0);
        tick();                                  // N+3
        check({tag, " vld@N+3"}, {fab_vld, wb_ack}, 2'b10);
        tick();
        check({tag, " vld one-shot"}, fab_vld, 1'b0);
    endtask

    initial begin
        logic [3:0] gseq;       // 1 = fabric grant, in order of observation
        int         ng, nwb, nfab, nboth;

        rst = 1'b1;
        wb_adr = '0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_be = 4'h0; wb_dat_w = '0;
        fab_req = 1'b0; fab_we = 1'b0; fab_adr = '0; fab_be = 4'h0; fab_dat_w = '0;
        tick();
        check("reset outputs", {wb_ack, fab_gnt, fab_vld, ram_ren, ram_wen}, 8'h00);
        check("reset wb_dat", wb_dat_r, 32'h0);
        check("reset fab_dat", fab_dat_r, 32'h0);
        check("reset ram_adr", ram_adr, 11'h0);
        rst = 1'b0;
        tick();
        tick();
        check("idle strobes", {ram_wen, ram_ren, fab_gnt}, 6'h0);

        // Wishbone full-word write then read back.
        do_wb("wb_wr", 1'b1, 11'h005, 32'hA5A5_1234, 4'hF, 32'h0);
        do_wb("wb_rd", 1'b0, 11'h005, 32'h0, 4'hF, 32'hA5A5_1234);

        // Fabric byte-lane write, then read back byte 1.
        do_fab("fab_wr", 1'b1, 11'h7FF, 32'h0000_BB00, 4'h2);
        do_fab("fab_rd", 1'b0, 11'h7FF, 32'h0, 4'hF);
        check("fab_rd byte1", fab_dat_r[15:8], 8'hBB);
        check("wb_dat held", wb_dat_r, 32'hA5A5_1234);

        // Reset during WAIT of a Wishbone read.
        wb_adr = 11'h005; wb_we = 1'b0; wb_be = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
        tick();                                  // XFER
        check("rst_case ren", ram_ren, 1'b1);
        tick();                                  // WAIT
        rst = 1'b1;
        #1;
        check("rst_case outputs", {wb_ack, fab_gnt, fab_vld, ram_ren, ram_wen}, 8'h00);
        check("rst_case wb_dat", wb_dat_r, 32'h0);
        tick();
        check("rst_case no ack", wb_ack, 1'b0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        rst = 1'b0;
        tick();

        // Simultaneous requests after reset: Wishbone first, then fabric.
        wb_adr = 11'h010; wb_we = 1'b1; wb_be = 4'hF; wb_dat_w = 32'h1111_2222;
        fab_adr = 11'h020; fab_we = 1'b1; fab_be = 4'hF; fab_dat_w = 32'h3333_4444;
        wb_cyc = 1'b1; wb_stb = 1'b1; fab_req = 1'b1;
        tick();                                  // N+1
        check("both N+1 wb strobe", {fab_gnt, ram_wen, ram_adr}, {1'b0, 4'hF, 11'h010});
        tick();
        tick();                                  // N+3
        check("both N+3 ack", {wb_ack, fab_vld}, 2'b10);
        tick();                                  // N+4 (skip cycle)
        wb_cyc = 1'b0; wb_stb = 1'b0;
        check("both N+4 idle", {fab_gnt, ram_wen}, 5'h0);
        tick();                                  // N+5
        check("both N+5 fab gnt", {fab_gnt, ram_wen, ram_adr}, {1'b1, 4'hF, 11'h020});
        fab_req = 1'b0;
        tick();
        tick();                                  // N+7
        check("both N+7 vld", {fab_vld, wb_ack}, 2'b10);
        tick();
        check("mem 0x010", mem[11'h010], 32'h1111_2222);
        check("mem 0x020", mem[11'h020], 32'h3333_4444);

        // Both sources requesting reads continuously for 16 cycles.
        wb_adr = 11'h005; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        fab_adr = 11'h7FF; fab_we = 1'b0; fab_req = 1'b1;
        gseq = 4'h0; ng = 0; nwb = 0; nfab = 0; nboth = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (wb_ack && fab_vld) nboth++;
            if (ram_ren || (ram_wen != 4'h0)) begin
                if (ng < 4) gseq[ng] = fab_gnt;
                ng++;
                if (fab_gnt) nfab++;
                else         nwb++;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; fab_req = 1'b0;
        check("contend grant count", ng, 4);
        check("contend wb grants", nwb, 2);
        check("contend fab grants", nfab, 2);
        check("contend order WB,FAB,WB,FAB", gseq, 4'b1010);
        check("contend ack&vld overlap", nboth, 0);
        check("contend wb_dat", wb_dat_r, 32'hA5A5_1234);
        tick();
        tick();
        tick();
        check("quiet idle", {ram_wen, ram_ren, fab_gnt, wb_ack, fab_vld}, 8'h00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
